reg_que_sched: RTL and testbench
================================

// Module: reg_que_sched
// PURPOSE
//  Read-side scheduler for the multi-queue shared-RAM FIFO. Picks one non-empty queue per cycle (round-robin, bursts of up to BURST_MAX),
//  drives its one-hot ren, and captures rdata after RD_LAT. Pushes {qid,data} into an OBUF_DEPTH-entry output buffer drained by a valid/ready master.
//  Sits directly downstream of the queue FIFO; feeds packet-parse stages.
// PARAMETERS
//  MQNUM      8   number of queues (>=1)
//  MQBIT      3   qid width, = max(1,ceil(log2(MQNUM)))
//  DWID       18  entry data width
//  RD_LAT     1   cycles from ren to valid rdata (1 = LOW_LATENCY RAM)
//  OBUF_DEPTH 4   output buffer entries, power of 2, >= RD_LAT+2
//  BURST_MAX  4   max consecutive grants to one queue (1 = pure round-robin)
// PORTS
//  clk      in  1           clock
//  rst      in  1           synchronous reset, active-high
//  nempty   in  MQNUM       per-queue not-empty from FIFO
//  naempty  in  MQNUM       per-queue not-almost-empty from FIFO
//  ren      out MQNUM       one-hot read enable to FIFO (combinational from state)
//  rdata    in  DWID        FIFO read data, valid RD_LAT cycles after ren
//  m_valid  out 1           output entry available
//  m_ready  in  1           consumer accepts entry when m_valid&m_ready
//  m_data   out DWID        entry data
//  m_qid    out MQBIT       source queue of entry
//  busy     out 1           reads in flight or buffer non-empty
// BEHAVIOUR
//  Reset: ren=0, m_valid=0, m_data=0, m_qid=0, busy=0; rr pointer=MQNUM-1, burst cnt=0, in-flight=0, buffer emptied.
//   Reset mid-operation discards in-flight reads and buffered entries; FIFO read pointers already advanced are not restored.
//  Eligibility of queue i: nempty[i] & !(i granted last cycle & !naempty[i]). This covers the FIFO flag update lag, so a
//   queue at or below AEMPTY_TH is never read on back-to-back cycles.
//  Credit: issue only when buf_cnt + inflight < OBUF_DEPTH, where inflight = grants in the last RD_LAT cycles.
//   A same-cycle pop (m_valid&m_ready) does not count toward credit that cycle.
//  FSM:
//   ARB: if credit & any eligible, grant the first eligible queue after the rr pointer (wrap MQNUM-1 -> 0).
//        Set rr pointer to that queue, burst cnt=1, go to BURST if BURST_MAX>1.
//   BURST: if credit & current queue eligible & cnt<BURST_MAX, re-grant it and increment cnt.
//        Otherwise fall to the ARB decision in the same cycle (no bubble). Its search starts after the current queue.
//  At most one ren bit high per cycle; ren=0 when there is no credit or no eligible queue.
//  Capture: grant qid is pipelined RD_LAT stages alongside a valid bit; rdata is written to the buffer with that qid on stage exit.
//  Output buffer: FIFO ordered, 0-cycle fall-through is not required. Entry is visible on m_* the cycle after its write.
//   Simultaneous push and pop are allowed at any fill, including full-with-pop.
//  Ordering: entries of one queue leave in FIFO order; across queues, in grant order.
//  busy = |inflight | (buf_cnt!=0).
//  Overflow of the buffer is impossible by credit rule; the bench asserts it.
// CONFIGURATION
//  REG_QUE_SCHED_PAUSE_EN defined: adds input port pause[MQNUM-1:0]. Queue i is ineligible while pause[i]=1.
//   Asserting pause ends an active burst on that queue at the next grant decision. In-flight reads still complete.
//  Not defined: no pause port; eligibility as above.
// TESTING
//  1. Reset, all nempty=0 -> ren=0, m_valid=0, busy=0 for 20 cycles.
//  2. Queue 2 holds 3 entries (0x11,0x12,0x13), m_ready=1, BURST_MAX=4 -> ren=0x04 for 3 cycles.
//     Output qid=2 data 0x11,0x12,0x13 in order, no gaps.
//  3. Queues 0,3,5 each hold 8 entries, BURST_MAX=1 -> grant order 0,3,5,0,3,5...; 24 entries out, per-queue order kept.
//  4. m_ready=0 with queue 1 full -> exactly OBUF_DEPTH reads issued then ren=0.
//     m_ready=1 resumes without loss or duplication.
//  5. Queue 4 nempty=1, naempty=0 (1 entry) -> single ren pulse, no re-grant next cycle; one output entry.
//  6. Mid-burst rst at cycle 5 -> next cycle ren=0, m_valid=0, busy=0. With PAUSE_EN, pause[0]=1 -> queue 0 never granted.

Source files
------------

// File: rtl/reg_que_sched.sv
`default_nettype none
// ============================================================================
// Module   : reg_que_sched
// Purpose  : Read-side scheduler for a multi-queue shared-RAM FIFO. Each cycle
//            it grants at most one eligible queue. Arbitration is round-robin,
//            and a granted queue may keep the grant for a burst of up to
//            BURST_MAX reads. The read data returns RD_LAT cycles after the
//            grant and is stored, tagged with its queue id, in an OBUF_DEPTH
//            entry output FIFO that a valid/ready consumer drains.
// Ports    : clk, rst          clock, synchronous active-high reset
//            nempty, naempty   per-queue not-empty / not-almost-empty flags
//            pause             per-queue hold-off (only with the macro below)
//            ren               one-hot read enable, combinational from state
//            rdata             FIFO read data, valid RD_LAT cycles after ren
//            m_valid/m_ready   output handshake; m_data, m_qid entry payload
//            busy              reads in flight or output buffer non-empty
// Config   : define REG_QUE_SCHED_PAUSE_EN to add the pause[MQNUM-1:0] input
// Revision : 1.0  initial release
// ============================================================================
module reg_que_sched #(
  parameter int MQNUM      = 8,
  parameter int MQBIT      = 3,
  parameter int DWID       = 18,
  parameter int RD_LAT     = 1,
  parameter int OBUF_DEPTH = 4,
  parameter int BURST_MAX  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MQNUM-1:0] nempty,
  input  logic [MQNUM-1:0] naempty,
`ifdef REG_QUE_SCHED_PAUSE_EN
  input  logic [MQNUM-1:0] pause,
`endif
  output logic [MQNUM-1:0] ren,
  input  logic [DWID-1:0]  rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DWID-1:0]  m_data,
  output logic [MQBIT-1:0] m_qid,
  output logic             busy
);

  localparam int OBIT = $clog2(OBUF_DEPTH);
  localparam int CBIT = $clog2(OBUF_DEPTH + 1);
  localparam int SBIT = CBIT + 1;
  localparam int IBIT = $clog2(RD_LAT + 1);
  localparam int BBIT = $clog2(BURST_MAX + 1);
  localparam logic [SBIT-1:0] DEPTH_C = SBIT'(OBUF_DEPTH);
  localparam logic [BBIT-1:0] BMAX_C  = BBIT'(BURST_MAX);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t                  state;
  logic [MQBIT-1:0]        rr_ptr;
  logic [BBIT-1:0]         burst_cnt;
  logic [MQNUM-1:0]        last_ren;
  logic [RD_LAT-1:0]       pipe_v;
  logic [MQBIT-1:0]        pipe_q [RD_LAT];
  logic [MQBIT+DWID-1:0]   obuf   [OBUF_DEPTH];
  logic [OBIT-1:0]         wr_ptr;
  logic [OBIT-1:0]         rd_ptr;
  logic [CBIT-1:0]         buf_cnt;

  logic [MQNUM-1:0]        elig;
  logic [IBIT-1:0]         inflight;
  logic [SBIT-1:0]         credit_sum;
  logic                    credit;
  logic                    arb_vld;
  logic [MQBIT-1:0]        arb_q;
  logic                    burst_go;
  logic                    grant_vld;
  logic                    grant_cont;
  logic [MQBIT-1:0]        grant_q;
  logic                    push;
  logic                    pop;

  // A queue read last cycle whose almost-empty flag is set may already be
  // drained (its flags lag the read by a cycle), so it sits out one cycle.
`ifdef REG_QUE_SCHED_PAUSE_EN
  assign elig = nempty & ~(last_ren & ~naempty) & ~pause;
`else
  assign elig = nempty & ~(last_ren & ~naempty);
`endif

  always_comb begin
    inflight = '0;
    for (int s = 0; s < RD_LAT; s++) begin
      inflight = inflight + IBIT'(pipe_v[s]);
    end
  end

  // Pops in this cycle are deliberately not credited back until next cycle.
  assign credit_sum = SBIT'(buf_cnt) + SBIT'(inflight);
  assign credit     = credit_sum < DEPTH_C;

  // First eligible queue strictly after rr_ptr, wrapping; rr_ptr itself is
  // the last candidate. Descending scan so the nearest candidate wins.
  always_comb begin
    int idx;
    idx     = 0;
    arb_vld = 1'b0;
    arb_q   = '0;
    for (int j = MQNUM; j >= 1; j--) begin
      idx = (int'(rr_ptr) + j) % MQNUM;
      if (elig[idx]) begin
        arb_vld = 1'b1;
        arb_q   = MQBIT'(idx);
      end
    end
  end

  assign burst_go = (state == ST_BURST) && elig[rr_ptr] && (burst_cnt < BMAX_C);

  always_comb begin
    grant_vld  = 1'b0;
    grant_cont = 1'b0;
    grant_q    = rr_ptr;
    if (!rst && credit) begin
      if (burst_go) begin
        grant_vld  = 1'b1;
        grant_cont = 1'b1;
      end else if (arb_vld) begin
        grant_vld = 1'b1;
        grant_q   = arb_q;
      end
    end
  end

  always_comb begin
    ren = '0;
    for (int i = 0; i < MQNUM; i++) begin
      ren[i] = grant_vld && (grant_q == MQBIT'(i));
    end
  end

  // Arbitration state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ARB;
      rr_ptr    <= MQBIT'(MQNUM - 1);
      burst_cnt <= '0;
      last_ren  <= '0;
    end else begin
      last_ren <= ren;
      if (grant_vld) begin
        if (grant_cont) begin
          burst_cnt <= burst_cnt + BBIT'(1);
        end else begin
          rr_ptr    <= grant_q;
          burst_cnt <= BBIT'(1);
          state     <= (BURST_MAX > 1) ? ST_BURST : ST_ARB;
        end
      end else begin
        state <= ST_ARB;
      end
    end
  end

  // Grant qid travels alongside the RAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < RD_LAT; s++) begin
        pipe_v[s] <= 1'b0;
        pipe_q[s] <= '0;
      end
    end else begin
      pipe_v[0] <= grant_vld;
      pipe_q[0] <= grant_q;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_v[s] <= pipe_v[s-1];
        pipe_q[s] <= pipe_q[s-1];
      end
    end
  end

  assign push = pipe_v[RD_LAT-1];
  assign pop  = m_valid && m_ready;

  // Output buffer; credit guarantees a push never meets a full buffer
  // without a matching pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      buf_cnt <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        obuf[i] <= '0;
      end
    end else begin
      if (push) begin
        obuf[wr_ptr] <= {pipe_q[RD_LAT-1], rdata};
        wr_ptr       <= wr_ptr + OBIT'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + OBIT'(1);
      end
      buf_cnt <= buf_cnt + CBIT'(push) - CBIT'(pop);
    end
  end

  assign m_valid         = (buf_cnt != '0);
  assign {m_qid, m_data} = obuf[rd_ptr];
  assign busy            = (|pipe_v) || m_valid;

endmodule
`default_nettype wire

// File: tb/tb_reg_que_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_que_sched
// Purpose  : Self-checking bench. Two schedulers (BURST_MAX 4 and 1) each
//            drive their own queue-FIFO model with lagging flags. A
//            transaction-level model predicts ren and the output stream every
//            cycle; directed scenarios pin the model with literal values.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_que_sched;

  localparam int MQNUM      = 8;
  localparam int MQBIT      = 3;
  localparam int DWID       = 18;
  localparam int RD_LAT     = 1;
  localparam int OBUF_DEPTH = 4;
  localparam int NI         = 2;
  localparam int FDEPTH     = 64;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic m_ready = 1'b1;
`ifdef REG_QUE_SCHED_PAUSE_EN
  logic [MQNUM-1:0] pause = '0;
`endif

  always #5 clk = ~clk;

  logic [MQNUM-1:0] nempty  [NI];
  logic [MQNUM-1:0] naempty [NI];
  logic [MQNUM-1:0] ren     [NI];
  logic [DWID-1:0]  rdata   [NI];
  logic             m_valid [NI];
  logic [DWID-1:0]  m_data  [NI];
  logic [MQBIT-1:0] m_qid   [NI];
  logic             busy    [NI];

  logic [DWID-1:0] fmem  [NI][MQNUM][FDEPTH];
  int              fhead [NI][MQNUM] = '{default: 0};
  int              ftail [NI][MQNUM] = '{default: 0};

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  for (genvar k = 0; k < NI; k++) begin : g_env
    localparam int BMAX = (k == 0) ? 4 : 1;

    reg_que_sched #(
      .MQNUM(MQNUM), .MQBIT(MQBIT), .DWID(DWID), .RD_LAT(RD_LAT),
      .OBUF_DEPTH(OBUF_DEPTH), .BURST_MAX(BMAX)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .nempty  (nempty[k]),
      .naempty (naempty[k]),
`ifdef REG_QUE_SCHED_PAUSE_EN
      .pause   (pause),
`endif
      .ren     (ren[k]),
      .rdata   (rdata[k]),
      .m_valid (m_valid[k]),
      .m_ready (m_ready),
      .m_data  (m_data[k]),
      .m_qid   (m_qid[k]),
      .busy    (busy[k])
    );

    // Queue FIFO: registered read, flags registered from the pre-read count
    // (one cycle behind), almost-empty threshold of one entry.
    always @(posedge clk) begin
      int cnt;
      for (int q = 0; q < MQNUM; q++) begin
        cnt = ftail[k][q] - fhead[k][q];
        nempty[k][q]  <= (cnt > 0);
        naempty[k][q] <= (cnt > 1);
        if (ren[k][q]) begin
          if (cnt == 0) begin
            n_total++;
            $display("FAIL fifo_underflow[%0d]: queue %0d read while empty at %0t", k, q, $time);
          end else begin
            rdata[k] <= fmem[k][q][fhead[k][q] % FDEPTH];
            fhead[k][q] = fhead[k][q] + 1;
          end
        end
      end
    end

    // Transaction model: round-robin pointer, burst length, entries in
    // flight and a queue of entries visible to the consumer.
    int  rr   = MQNUM - 1;
    int  bcnt = 0;
    int  last = -1;
    bit  inb  = 1'b0;
    int  pq [RD_LAT] = '{default: -1};
    logic [DWID-1:0] pd [RD_LAT];
    logic [MQBIT+DWID-1:0] mbuf [$];

    always @(negedge clk) begin
      int g, infl, i;
      bit cont, credit, ev, eb;
      logic [MQNUM-1:0] el, eren;
      logic [MQBIT+DWID-1:0] ent;
      logic [MQBIT-1:0] qq;
      infl = 0;
      for (int s = 0; s < RD_LAT; s++) if (pq[s] >= 0) infl++;
      for (int j = 0; j < MQNUM; j++) begin
        el[j] = nempty[k][j] && !(last == j && !naempty[k][j]);
`ifdef REG_QUE_SCHED_PAUSE_EN
        if (pause[j]) el[j] = 1'b0;
`endif
      end
      credit = (mbuf.size() + infl) < OBUF_DEPTH;
      g = -1;
      cont = 1'b0;
      if (!rst && credit) begin
        if (inb && el[rr] && bcnt < BMAX) begin
          g = rr;
          cont = 1'b1;
        end else begin
          for (int j = 1; j <= MQNUM; j++) begin
            i = (rr + j) % MQNUM;
            if (g < 0 && el[i]) g = i;
          end
        end
      end
      eren = '0;
      if (g >= 0) eren[g] = 1'b1;
      ev = (mbuf.size() != 0);
      eb = (infl != 0) || ev;
      if (chk_en) begin
        check($sformatf("ren[%0d]", k), ren[k], eren);
        check($sformatf("m_valid[%0d]", k), m_valid[k], ev);
        check($sformatf("busy[%0d]", k), busy[k], eb);
        if (ev) begin
          ent = mbuf[0];
          check($sformatf("m_qid[%0d]", k), m_qid[k], ent[DWID +: MQBIT]);
          check($sformatf("m_data[%0d]", k), m_data[k], ent[DWID-1:0]);
        end
      end
      if (rst) begin
        rr = MQNUM - 1; bcnt = 0; last = -1; inb = 1'b0;
        for (int s = 0; s < RD_LAT; s++) pq[s] = -1;
        mbuf.delete();
      end else begin
        if (ev && m_ready) void'(mbuf.pop_front());
        if (pq[RD_LAT-1] >= 0) begin
          qq = pq[RD_LAT-1][MQBIT-1:0];
          mbuf.push_back({qq, pd[RD_LAT-1]});
        end
        for (int s = RD_LAT - 1; s >= 1; s--) begin
          pq[s] = pq[s-1];
          pd[s] = pd[s-1];
        end
        pq[0] = g;
        pd[0] = (g >= 0) ? fmem[k][g][fhead[k][g] % FDEPTH] : '0;
        if (g >= 0) begin
          if (cont) bcnt++;
          else begin
            rr = g; bcnt = 1; inb = (BMAX > 1);
          end
        end else begin
          inb = 1'b0;
        end
        last = g;
        if (chk_en && mbuf.size() > OBUF_DEPTH) begin
          n_total++;
          $display("FAIL obuf_overflow[%0d]: %0d entries at %0t", k, mbuf.size(), $time);
        end
      end
    end
  end

  // Load n entries (base, base+1, ...) into queue q of both FIFO models.
  task automatic load(input int q, input int n, input int base);
    for (int k = 0; k < NI; k++) begin
      for (int e = 0; e < n; e++) begin
        fmem[k][q][ftail[k][q] % FDEPTH] = DWID'(base + e);
        ftail[k][q] = ftail[k][q] + 1;
      end
    end
  endtask

  function automatic bit all_drained();
    bit d;
    d = 1'b1;
    for (int k = 0; k < NI; k++) begin
      if (busy[k] || ren[k] != '0) d = 1'b0;
      for (int q = 0; q < MQNUM; q++) if (ftail[k][q] != fhead[k][q]) d = 1'b0;
    end
    return d;
  endfunction

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      done = all_drained();
    end
    check(name, done, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int n4, nbad, nout, first, lastc, okd, err, ng;
    int nr [NI];
    int no [NI];
    int nx [MQNUM];
    int ord [3] = '{0, 3, 5};

    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_ren[%0d]", k), ren[k], 0);
      check($sformatf("rst_m_valid[%0d]", k), m_valid[k], 0);
      check($sformatf("rst_m_data[%0d]", k), m_data[k], 0);
      check($sformatf("rst_m_qid[%0d]", k), m_qid[k], 0);
      check($sformatf("rst_busy[%0d]", k), busy[k], 0);
    end
    @(posedge clk); #1 rst = 1'b0;

    // 1: idle for 20 cycles
    okd = 1;
    repeat (20) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) if (ren[k] != 0 || m_valid[k] || busy[k]) okd = 0;
    end
    check("t1_idle20", okd, 1);

    // 2: three entries on queue 2, BURST_MAX=4 instance
    @(posedge clk); #1 load(2, 3, 'h11);
    n4 = 0; nbad = 0; nout = 0; first = -1; lastc = -1; okd = 1; ng = -1; err = -1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (ren[0] == 8'h04) begin
        n4++;
        if (ng < 0) ng = c;
        err = c;
      end else if (ren[0] != 0) nbad++;
      if (m_valid[0] && m_ready) begin
        if (m_qid[0] != 2 || m_data[0] != DWID'('h11 + nout)) okd = 0;
        if (first < 0) first = c;
        lastc = c;
        nout++;
      end
    end
    check("t2_ren04_cycles", n4, 3);
    check("t2_ren04_span", err - ng, 2);
    check("t2_other_ren", nbad, 0);
    check("t2_nout", nout, 3);
    check("t2_data", okd, 1);
    check("t2_out_span", lastc - first, 2);
    wait_idle("t2_drain");

    // 3: queues 0,3,5 with 8 entries each; pure round-robin instance
    pulse_reset();
    @(posedge clk); #1 load(0, 8, 'h000); load(3, 8, 'h300); load(5, 8, 'h500);
    ng = 0; err = 0; nout = 0; okd = 1;
    for (int q = 0; q < MQNUM; q++) nx[q] = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (ren[1] != 0) begin
        if (ren[1] != (8'h01 << ord[ng % 3])) err++;
        ng++;
      end
      if (m_valid[1] && m_ready) begin
        if (m_data[1] != DWID'(int'(m_qid[1]) * 'h100 + nx[m_qid[1]])) okd = 0;
        nx[m_qid[1]]++;
        nout++;
      end
    end
    check("t3_grants", ng, 24);
    check("t3_order_err", err, 0);
    check("t3_nout", nout, 24);
    check("t3_perq_order", okd, 1);
    wait_idle("t3_drain");

    // 4: consumer stalled, queue 1 has 8 entries
    @(posedge clk); #1 m_ready = 1'b0; load(1, 8, 'h1A0);
    for (int k = 0; k < NI; k++) nr[k] = 0;
    repeat (20) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) if (ren[k] != 0) nr[k]++;
    end
    check("t4_reads_b4", nr[0], OBUF_DEPTH);
    check("t4_reads_b1", nr[1], OBUF_DEPTH);
    @(posedge clk); #1 m_ready = 1'b1;
    no[0] = 0; okd = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_valid[0] && m_ready) begin
        if (m_qid[0] != 1 || m_data[0] != DWID'('h1A0 + no[0])) okd = 0;
        no[0]++;
      end
    end
    check("t4_nout", no[0], 8);
    check("t4_data", okd, 1);
    wait_idle("t4_drain");

    // 5: single entry on queue 4 (nempty=1, naempty=0)
    @(posedge clk); #1 load(4, 1, 'h2BC);
    for (int k = 0; k < NI; k++) begin nr[k] = 0; no[k] = 0; end
    nbad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (ren[k] == 8'h10) nr[k]++;
        else if (ren[k] != 0) nbad++;
        if (m_valid[k] && m_ready) begin
          no[k]++;
          if (m_data[k] != DWID'('h2BC) || m_qid[k] != 4) nbad++;
        end
      end
    end
    check("t5_pulses_b4", nr[0], 1);
    check("t5_pulses_b1", nr[1], 1);
    check("t5_nout", no[0] + no[1], 2);
    check("t5_bad", nbad, 0);
    wait_idle("t5_drain");

    // 6: reset in the middle of a burst
    @(posedge clk); #1 load(6, 8, 'h600);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("t6_ren[%0d]", k), ren[k], 0);
      check($sformatf("t6_m_valid[%0d]", k), m_valid[k], 0);
      check($sformatf("t6_busy[%0d]", k), busy[k], 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    wait_idle("t6_drain");

`ifdef REG_QUE_SCHED_PAUSE_EN
    @(posedge clk); #1 pause = 8'h01; load(0, 4, 'h700); load(1, 4, 'h710);
    nbad = 0;
    repeat (30) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) if (ren[k][0]) nbad++;
    end
    check("t6_pause_q0_grants", nbad, 0);
    @(posedge clk); #1 pause = '0;
    wait_idle("t6_pause_drain");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
